// File: rtl/baud_rate_ctrl.sv
// Baud rate controller: free-running x16 oversampling tick generator whose
// divisor is set either by a manual write or by measuring one start bit.
module baud_rate_ctrl #(
  parameter int DIV_W       = 12,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 163,
  parameter int MIN_CNT     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             auto_start,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             s_tick,
  output logic [DIV_W-1:0] div_out,
  output logic             locked,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_FALL,
    MEASURE,
    CALC
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT_C = CNT_W'(MIN_CNT);
  localparam logic [DIV_W-1:0] DIV_MAX   = '1;
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] measCnt_q, measCnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tickCnt_q;
  logic [DIV_W-1:0] autoDiv;
  logic [31:0]      calcDiv;
  logic             rxMeta_q, rxSync_q;
  logic             locked_q, busy_q, err_q, err_d, sTick_q;
  logic             divLoad, cfgValid;

  assign cfgValid = cfg_we && (cfg_div >= DIV_FLOOR);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // Convert the measured start-bit length to a x16 divisor, rounded, saturated and floored at 2.
  always_comb begin
    calcDiv = (32'(measCnt_q) + 32'd8) >> 4;
    if (calcDiv > 32'(DIV_MAX)) begin
      autoDiv = DIV_MAX;
    end else if (calcDiv < 32'd2) begin
      autoDiv = DIV_FLOOR;
    end else begin
      autoDiv = DIV_W'(calcDiv);
    end
  end

  // Autobaud next-state logic; a valid manual write overrides everything.
  always_comb begin
    state_d   = state_q;
    measCnt_d = measCnt_q;
    div_d     = div_q;
    divLoad   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (auto_start) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rxSync_q) state_d = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (!rxSync_q) begin
          state_d   = MEASURE;
          measCnt_d = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (rxSync_q) begin
          state_d = CALC;
        end else if (measCnt_q == CNT_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          measCnt_d = measCnt_q + CNT_W'(1);
        end
      end
      CALC: begin
        state_d = IDLE;
        if (measCnt_q < MIN_CNT_C) begin
          err_d = 1'b1;
        end else begin
          divLoad = 1'b1;
          div_d   = autoDiv;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cfgValid) begin
      state_d = IDLE;
      err_d   = 1'b0;
      divLoad = 1'b1;
      div_d   = cfg_div;
    end
  end

  // FSM state, measurement counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      measCnt_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      measCnt_q <= measCnt_d;
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
    end
  end

  // Divisor register; any load marks the divisor as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_RESET;
      locked_q <= 1'b0;
    end else if (divLoad) begin
      div_q    <= div_d;
      locked_q <= 1'b1;
    end
  end

  // Tick counter runs 0..div-1 and restarts whenever the divisor is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
      sTick_q   <= 1'b0;
    end else if (divLoad) begin
      tickCnt_q <= '0;
      sTick_q   <= 1'b0;
    end else if (tickCnt_q == div_q - DIV_W'(1)) begin
      tickCnt_q <= '0;
      sTick_q   <= 1'b1;
    end else begin
      tickCnt_q <= tickCnt_q + DIV_W'(1);
      sTick_q   <= 1'b0;
    end
  end

  assign s_tick  = sTick_q;
  assign div_out = div_q;
  assign locked  = locked_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
